// File: rtl/banzai_axil.sv
// AXI4-Lite accelerator tile: 64-word scratch memory, control/status registers and a
// word-sum engine that reduces MEM[0..LEN-1] into RESULT.
module banzai_axil #(
  parameter int unsigned MEM_WORDS = 64,
  parameter logic [31:0] ID_VALUE  = 32'hBA2A_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] aw_addr,
  input  logic [2:0]  aw_prot,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_valid,
  output logic        w_ready,
  output logic [1:0]  b_resp,
  output logic        b_valid,
  input  logic        b_ready,
  input  logic [31:0] ar_addr,
  input  logic [2:0]  ar_prot,
  input  logic        ar_valid,
  output logic        ar_ready,
  output logic [31:0] r_data,
  output logic [1:0]  r_resp,
  output logic        r_valid,
  input  logic        r_ready
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  localparam logic [9:0] OffCtrl   = 10'h040;
  localparam logic [9:0] OffLen    = 10'h041;
  localparam logic [9:0] OffStatus = 10'h042;
  localparam logic [9:0] OffResult = 10'h043;
  localparam logic [9:0] OffId     = 10'h044;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  logic [31:0] mem_q [MEM_WORDS];
  logic        aw_ready_q, ar_ready_q, b_valid_q, r_valid_q;
  logic [1:0]  b_resp_q, r_resp_q;
  logic [31:0] r_data_q;
  logic [6:0]  len_q, len_lat_q, idx_q;
  logic [31:0] result_q;
  logic        busy_q, done_q;

  logic        wr_fire, rd_fire;
  logic [9:0]  wr_off, rd_off;
  logic        wr_is_mem, rd_is_mem;
  logic        wr_err, mem_we, len_we, start;
  logic [6:0]  len_wdata;
  logic        rd_err;
  logic [31:0] rd_data;
  logic        eng_last;
  logic [31:0] eng_word;

  // Address bits outside [11:2] and the protection fields carry no meaning for this tile.
  logic unused_sigs;
  assign unused_sigs = ^{aw_prot, ar_prot, aw_addr[31:12], aw_addr[1:0],
                         ar_addr[31:12], ar_addr[1:0]};

  assign wr_fire   = aw_ready_q & aw_valid & w_valid;
  assign rd_fire   = ar_ready_q & ar_valid;
  assign wr_off    = aw_addr[11:2];
  assign rd_off    = ar_addr[11:2];
  assign wr_is_mem = (wr_off[9:AW] == '0);
  assign rd_is_mem = (rd_off[9:AW] == '0);
  assign len_wdata = (w_data > 32'd64) ? 7'd64 : w_data[6:0];

  always_comb begin
    wr_err = 1'b0;
    mem_we = 1'b0;
    len_we = 1'b0;
    start  = 1'b0;
    if (wr_is_mem) begin
      if (busy_q) wr_err = 1'b1;
      else        mem_we = wr_fire;
    end else begin
      case (wr_off)
        OffCtrl: start  = wr_fire & w_strb[0] & w_data[0] & ~busy_q;
        OffLen:  len_we = wr_fire & w_strb[0];
        default: wr_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    rd_err  = 1'b0;
    rd_data = '0;
    if (rd_is_mem) begin
      rd_data = mem_q[rd_off[AW-1:0]];
    end else begin
      case (rd_off)
        OffCtrl:   rd_data = '0;
        OffLen:    rd_data = {25'd0, len_q};
        OffStatus: rd_data = {30'd0, done_q, busy_q};
        OffResult: rd_data = result_q;
        OffId:     rd_data = ID_VALUE;
        default:   rd_err  = 1'b1;
      endcase
    end
  end

  // A zero length still spends one busy cycle so DONE always follows a visible BUSY.
  assign eng_last = (len_lat_q == 7'd0) || (idx_q + 7'd1 == len_lat_q);
  assign eng_word = mem_q[idx_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_ready_q <= 1'b0;
      ar_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      b_resp_q   <= RespOkay;
      r_resp_q   <= RespOkay;
      r_data_q   <= '0;
      len_q      <= '0;
      len_lat_q  <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < int'(MEM_WORDS); i++) mem_q[i] <= '0;
    end else begin
      aw_ready_q <= aw_valid & w_valid & ~b_valid_q & ~aw_ready_q;
      ar_ready_q <= ar_valid & ~r_valid_q & ~ar_ready_q;

      if (wr_fire) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_err ? RespSlverr : RespOkay;
      end else if (b_ready) begin
        b_valid_q <= 1'b0;
      end

      if (rd_fire) begin
        r_valid_q <= 1'b1;
        r_resp_q  <= rd_err ? RespSlverr : RespOkay;
        r_data_q  <= rd_err ? 32'd0 : rd_data;
      end else if (r_ready) begin
        r_valid_q <= 1'b0;
      end

      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb[b]) mem_q[wr_off[AW-1:0]][8*b +: 8] <= w_data[8*b +: 8];
        end
      end

      if (len_we) len_q <= len_wdata;

      if (start) begin
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
        result_q  <= '0;
        idx_q     <= '0;
        len_lat_q <= len_q;
      end else if (busy_q) begin
        if (len_lat_q != 7'd0) begin
          result_q <= result_q + eng_word;
          idx_q    <= idx_q + 7'd1;
        end
        if (eng_last) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign aw_ready = aw_ready_q;
  assign w_ready  = aw_ready_q;
  assign ar_ready = ar_ready_q;
  assign b_valid  = b_valid_q;
  assign b_resp   = b_resp_q;
  assign r_valid  = r_valid_q;
  assign r_resp   = r_resp_q;
  assign r_data   = r_data_q;

endmodule

// File: tb/tb_banzai_axil.sv
// Self-checking bench for banzai_axil: randomized register/memory traffic and reductions
// checked against a plain-arithmetic model of the tile's memory, LEN and RESULT.
module tb_banzai_axil;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic [2:0]  aw_prot, ar_prot;
  logic [3:0]  w_strb;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [1:0]  b_resp, r_resp;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_mem [64];
  int unsigned model_len;

  always #5 clk = ~clk;

  banzai_axil dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .aw_addr  (aw_addr),
    .aw_prot  (aw_prot),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .w_data   (w_data),
    .w_strb   (w_strb),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .b_resp   (b_resp),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .ar_addr  (ar_addr),
    .ar_prot  (ar_prot),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .r_data   (r_data),
    .r_resp   (r_resp),
    .r_valid  (r_valid),
    .r_ready  (r_ready)
  );

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    int t;
    @(negedge clk);
    aw_addr = addr; aw_prot = 3'($urandom); w_data = data; w_strb = strb;
    aw_valid = 1'b1; w_valid = 1'b1;
    t = 0;
    while (!(aw_ready && w_ready) && t < 20) begin @(negedge clk); t++; end
    if (!(aw_ready && w_ready)) begin
      n_cmp++; n_err++;
      $display("FAIL wr_accept_timeout addr=%h got ready=%b want 1", addr, aw_ready);
      aw_valid = 1'b0; w_valid = 1'b0; resp = 2'bxx;
      return;
    end
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!b_valid && t < 20) begin @(negedge clk); t++; end
    if (!b_valid) begin
      n_cmp++; n_err++;
      $display("FAIL wr_resp_timeout addr=%h got b_valid=0 want 1", addr);
      resp = 2'bxx;
      return;
    end
    resp = b_resp;
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    int t;
    @(negedge clk);
    ar_addr = addr; ar_prot = 3'($urandom); ar_valid = 1'b1;
    t = 0;
    while (!ar_ready && t < 20) begin @(negedge clk); t++; end
    if (!ar_ready) begin
      n_cmp++; n_err++;
      $display("FAIL rd_accept_timeout addr=%h got ar_ready=0 want 1", addr);
      ar_valid = 1'b0; data = 'x; resp = 2'bxx;
      return;
    end
    @(posedge clk); #1;
    ar_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!r_valid && t < 20) begin @(negedge clk); t++; end
    if (!r_valid) begin
      n_cmp++; n_err++;
      $display("FAIL rd_resp_timeout addr=%h got r_valid=0 want 1", addr);
      data = 'x; resp = 2'bxx;
      return;
    end
    data = r_data; resp = r_resp;
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
  endtask

  // Reads STATUS until DONE or the read budget runs out; returns the last value seen.
  task automatic poll_done(output logic [31:0] st);
    logic [1:0] rs;
    st = '0;
    for (int i = 0; i < 200; i++) begin
      do_read(32'h108, st, rs);
      if (st[1] === 1'b1) return;
    end
  endtask

  function automatic logic [31:0] model_sum(input int unsigned len);
    logic [31:0] s = '0;
    for (int i = 0; i < int'(len); i++) s = s + model_mem[i];
    return s;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    model_len = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  rs;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    aw_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0;
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if ({aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp, r_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got rdy=%b%b%b bv=%b rv=%b br=%b rr=%b rd=%h want all 0",
               aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp, r_data);
    end
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(32'h110, d, rs);
    n_cmp++;
    if (d !== 32'hBA2A_0001 || rs !== 2'b00) begin
      n_err++; $display("FAIL reset_id got %h/%b want ba2a0001/00", d, rs);
    end
    do_read(32'h108, d, rs);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reset_status got %h want 0", d); end
    do_read(32'h104, d, rs);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reset_len got %h want 0", d); end
    do_read(32'h10C, d, rs);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", d); end
  endtask

  task automatic test_mem_rw();
    logic [31:0] d, a, v;
    logic [1:0]  rs;
    logic [3:0]  s;
    int          w;
    do_write(32'h014, 32'hCAFE_F00D, 4'hF, rs);
    model_mem[5] = 32'hCAFE_F00D;
    do_read(32'h014, d, rs);
    n_cmp++;
    if (d !== 32'hCAFE_F00D || rs !== 2'b00) begin
      n_err++; $display("FAIL mem_full_word got %h/%b want cafef00d/00", d, rs);
    end
    do_write(32'h014, 32'h0000_00AA, 4'b0001, rs);
    model_mem[5][7:0] = 8'hAA;
    do_read(32'h014, d, rs);
    n_cmp++;
    if (d !== 32'hCAFE_F0AA) begin n_err++; $display("FAIL mem_strb got %h want cafef0aa", d); end
    for (int k = 0; k < 40; k++) begin
      w = int'($urandom_range(0, 63));
      v = $urandom;
      s = 4'($urandom);
      a = {20'($urandom), 10'(w), 2'($urandom)};
      do_write(a, v, s, rs);
      n_cmp++;
      if (rs !== 2'b00) begin n_err++; $display("FAIL mem_wr_resp got %b want 00", rs); end
      for (int b = 0; b < 4; b++) if (s[b]) model_mem[w][8*b +: 8] = v[8*b +: 8];
    end
    for (int i = 0; i < 64; i++) begin
      do_read(32'(i * 4), d, rs);
      n_cmp++;
      if (d !== model_mem[i] || rs !== 2'b00) begin
        n_err++;
        $display("FAIL mem_readback[%0d] got %h/%b want %h/00", i, d, rs, model_mem[i]);
      end
    end
  endtask

  task automatic test_len_clamp();
    logic [31:0] d, v;
    logic [1:0]  rs;
    logic [31:0] vals [5];
    vals[0] = 32'd100; vals[1] = 32'd64; vals[2] = 32'd65; vals[3] = 32'd0;
    vals[4] = 32'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      v = vals[i];
      do_write(32'h104, v, 4'hF, rs);
      model_len = (v > 64) ? 64 : v;
      do_read(32'h104, d, rs);
      n_cmp++;
      if (d !== 32'(model_len)) begin
        n_err++; $display("FAIL len_clamp wrote %0d got %0d want %0d", v, d, model_len);
      end
    end
    // LEN ignores writes whose lowest byte lane is disabled.
    do_write(32'h104, 32'd7, 4'b1110, rs);
    do_read(32'h104, d, rs);
    n_cmp++;
    if (d !== 32'(model_len)) begin
      n_err++; $display("FAIL len_strb got %0d want %0d", d, model_len);
    end
  endtask

  task automatic run_sum(input int unsigned len, input string tag);
    logic [31:0] d;
    logic [1:0]  rs;
    do_write(32'h104, 32'(len), 4'hF, rs);
    model_len = len;
    do_write(32'h100, 32'h1, 4'hF, rs);
    poll_done(d);
    n_cmp++;
    if (d !== 32'h2) begin n_err++; $display("FAIL %s_status got %h want 2", tag, d); end
    do_read(32'h10C, d, rs);
    n_cmp++;
    if (d !== model_sum(len) || rs !== 2'b00) begin
      n_err++; $display("FAIL %s_result len=%0d got %h want %h", tag, len, d, model_sum(len));
    end
  endtask

  task automatic test_sum();
    logic [1:0]  rs;
    logic [31:0] seed [4];
    seed[0] = 32'd1; seed[1] = 32'd2; seed[2] = 32'd3; seed[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      do_write(32'(i * 4), seed[i], 4'hF, rs);
      model_mem[i] = seed[i];
    end
    run_sum(4, "sum_wrap");
    for (int k = 0; k < 3; k++) run_sum($urandom_range(1, 64), "sum_rand");
    run_sum(64, "sum_full");
  endtask

  task automatic test_len_zero();
    logic [31:0] d;
    logic [1:0]  rs;
    run_sum(0, "len0");
    do_read(32'h100, d, rs);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL ctrl_reads_zero got %h want 0", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic [1:0]  rs;
    logic [31:0] bad [4];
    bad[0] = 32'h110; bad[1] = 32'h108; bad[2] = 32'h10C; bad[3] = 32'h200;
    for (int i = 0; i < 4; i++) begin
      do_write(bad[i], $urandom, 4'hF, rs);
      n_cmp++;
      if (rs !== 2'b10) begin n_err++; $display("FAIL wr_slverr @%h got %b want 10", bad[i], rs); end
    end
    do_read(32'h200, d, rs);
    n_cmp++;
    if (d !== 32'h0 || rs !== 2'b10) begin
      n_err++; $display("FAIL rd_unmapped got %h/%b want 0/10", d, rs);
    end
    do_read(32'($urandom_range(32'h114, 32'hFFC)) & 32'hFFC | 32'h800, d, rs);
    n_cmp++;
    if (d !== 32'h0 || rs !== 2'b10) begin
      n_err++; $display("FAIL rd_unmapped_rand got %h/%b want 0/10", d, rs);
    end
    do_read(32'hFFFF_F113, d, rs);
    n_cmp++;
    if (d !== 32'hBA2A_0001 || rs !== 2'b00) begin
      n_err++; $display("FAIL id_alias got %h/%b want ba2a0001/00", d, rs);
    end
  endtask

  task automatic test_busy();
    logic [31:0] d;
    logic [1:0]  rs;
    do_write(32'h104, 32'd64, 4'hF, rs);
    do_write(32'h100, 32'h1, 4'hF, rs);
    do_read(32'h108, d, rs);
    n_cmp++;
    if (d !== 32'h1) begin n_err++; $display("FAIL busy_status got %h want 1", d); end
    do_write(32'h000, ~model_mem[0], 4'hF, rs);
    n_cmp++;
    if (rs !== 2'b10) begin n_err++; $display("FAIL busy_mem_wr got %b want 10", rs); end
    do_write(32'h104, 32'd3, 4'hF, rs);
    model_len = 3;
    do_write(32'h100, 32'h1, 4'hF, rs);
    n_cmp++;
    if (rs !== 2'b00) begin n_err++; $display("FAIL busy_restart_resp got %b want 00", rs); end
    do_read(32'h000, d, rs);
    n_cmp++;
    if (d !== model_mem[0]) begin n_err++; $display("FAIL busy_mem_kept got %h want %h", d, model_mem[0]); end
    poll_done(d);
    n_cmp++;
    if (d !== 32'h2) begin n_err++; $display("FAIL busy_done got %h want 2", d); end
    do_read(32'h10C, d, rs);
    n_cmp++;
    if (d !== model_sum(64)) begin
      n_err++; $display("FAIL busy_result got %h want %h", d, model_sum(64));
    end
    do_read(32'h104, d, rs);
    n_cmp++;
    if (d !== 32'd3) begin n_err++; $display("FAIL busy_len_rewrite got %0d want 3", d); end
  endtask

  task automatic test_same_word();
    logic [31:0] d, v, rd;
    logic [1:0]  rs, wr_rs, rd_rs;
    int          w, t;
    w = int'($urandom_range(0, 63));
    v = ~model_mem[w];
    @(negedge clk);
    aw_addr = 32'(w * 4); w_data = v; w_strb = 4'hF; ar_addr = 32'(w * 4);
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    t = 0;
    while (!(aw_ready && ar_ready) && t < 20) begin @(negedge clk); t++; end
    n_cmp++;
    if (!(aw_ready && ar_ready)) begin
      n_err++; $display("FAIL same_edge_accept got aw=%b ar=%b want 1/1", aw_ready, ar_ready);
    end
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    @(negedge clk);
    rd = r_data; rd_rs = r_resp; wr_rs = b_resp;
    n_cmp++;
    if (!(r_valid && b_valid) || rd !== model_mem[w] || rd_rs !== 2'b00 || wr_rs !== 2'b00) begin
      n_err++;
      $display("FAIL same_word_old got v=%b%b d=%h want 11 %h", r_valid, b_valid, rd, model_mem[w]);
    end
    r_ready = 1'b1; b_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0; b_ready = 1'b0;
    model_mem[w] = v;
    do_read(32'(w * 4), d, rs);
    n_cmp++;
    if (d !== v) begin n_err++; $display("FAIL same_word_new got %h want %h", d, v); end
  endtask

  task automatic test_reset_clears();
    logic [31:0] d;
    logic [1:0]  rs;
    apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_read(32'(i * 4), d, rs);
      n_cmp++;
      if (d !== 32'h0) begin n_err++; $display("FAIL rereset_mem[%0d] got %h want 0", i, d); end
    end
    do_read(32'h104, d, rs);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL rereset_len got %h want 0", d); end
    do_read(32'h108, d, rs);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL rereset_status got %h want 0", d); end
    do_read(32'h10C, d, rs);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL rereset_result got %h want 0", d); end
  endtask

  initial begin
    rst_n = 1'b0;
    aw_addr = '0; aw_prot = '0; aw_valid = 1'b0; w_data = '0; w_strb = '0; w_valid = 1'b0;
    b_ready = 1'b0; ar_addr = '0; ar_prot = '0; ar_valid = 1'b0; r_ready = 1'b0;
    model_len = 0;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    test_reset();
    test_mem_rw();
    test_len_clamp();
    test_sum();
    test_len_zero();
    test_errors();
    test_busy();
    test_same_word();
    test_reset_clears();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
